// File: rtl/alu_control_if.sv
// alu_control_if: operand/code inputs and registered result outputs of the execute-stage ALU
interface alu_control_if;
    logic [6:0]  opcode;
    logic [3:0]  func_code;
    logic [31:0] a;
    logic [31:0] b;
    logic [6:0]  alu_ctl;
    logic [31:0] alu_out;
    logic        branch_enable;

    modport master (
        output opcode, func_code, a, b,
        input  alu_ctl, alu_out, branch_enable
    );

    modport slave (
        input  opcode, func_code, a, b,
        output alu_ctl, alu_out, branch_enable
    );
endinterface

// File: rtl/alu_control.sv
// alu_control: RV32I ALU-control decode, 32-bit ALU and branch evaluation with registered outputs
module alu_control (
    input logic clk,
    input logic reset,
    alu_control_if.slave bus
);
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SRL  = 4'b0011;
    localparam logic [3:0] OP_SRA  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_XOR  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;
    localparam logic [3:0] OP_PASS = 4'b1010;
    localparam logic [3:0] OP_NOP  = 4'b1111;

    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_EQ   = 3'b001;
    localparam logic [2:0] BR_NE   = 3'b010;
    localparam logic [2:0] BR_LT   = 3'b011;
    localparam logic [2:0] BR_GE   = 3'b100;
    localparam logic [2:0] BR_LTU  = 3'b101;
    localparam logic [2:0] BR_GEU  = 3'b110;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    logic [3:0]  op;
    logic [2:0]  br;
    logic [31:0] result;
    logic        taken;
    logic [2:0]  f3;
    logic [4:0]  shamt;
    logic        lt_s;
    logic        lt_u;

    assign f3    = bus.func_code[2:0];
    assign shamt = bus.b[4:0];
    assign lt_s  = $signed(bus.a) < $signed(bus.b);
    assign lt_u  = bus.a < bus.b;

    // Decode opcode and function code into the operation and branch-condition fields
    always_comb begin
        op = OP_NOP;
        br = BR_NONE;
        case (bus.opcode)
            OPC_OP: begin
                case (bus.func_code)
                    4'b0000: op = OP_ADD;
                    4'b1000: op = OP_SUB;
                    4'b0001: op = OP_SLL;
                    4'b0010: op = OP_SLT;
                    4'b0011: op = OP_SLTU;
                    4'b0100: op = OP_XOR;
                    4'b0101: op = OP_SRL;
                    4'b1101: op = OP_SRA;
                    4'b0110: op = OP_OR;
                    4'b0111: op = OP_AND;
                    default: op = OP_NOP;
                endcase
            end
            // Immediate forms ignore instr[30] except to pick arithmetic right shift
            OPC_OP_IMM: begin
                case (f3)
                    3'b000:  op = OP_ADD;
                    3'b001:  op = OP_SLL;
                    3'b010:  op = OP_SLT;
                    3'b011:  op = OP_SLTU;
                    3'b100:  op = OP_XOR;
                    3'b101:  op = bus.func_code[3] ? OP_SRA : OP_SRL;
                    3'b110:  op = OP_OR;
                    default: op = OP_AND;
                endcase
            end
            OPC_LOAD, OPC_STORE, OPC_AUIPC, OPC_JAL, OPC_JALR: op = OP_ADD;
            OPC_LUI: op = OP_PASS;
            OPC_BRANCH: begin
                op = OP_SUB;
                case (f3)
                    3'b000:  br = BR_EQ;
                    3'b001:  br = BR_NE;
                    3'b100:  br = BR_LT;
                    3'b101:  br = BR_GE;
                    3'b110:  br = BR_LTU;
                    3'b111:  br = BR_GEU;
                    default: br = BR_NONE;
                endcase
            end
            default: begin
                op = OP_NOP;
                br = BR_NONE;
            end
        endcase
    end

    // Compute the ALU result for the decoded operation
    always_comb begin
        case (op)
            OP_AND:  result = bus.a & bus.b;
            OP_OR:   result = bus.a | bus.b;
            OP_ADD:  result = bus.a + bus.b;
            OP_SRL:  result = bus.a >> shamt;
            OP_SRA:  result = $signed(bus.a) >>> shamt;
            OP_SLL:  result = bus.a << shamt;
            OP_SUB:  result = bus.a - bus.b;
            OP_SLT:  result = {31'd0, lt_s};
            OP_XOR:  result = bus.a ^ bus.b;
            OP_SLTU: result = {31'd0, lt_u};
            OP_PASS: result = bus.b;
            default: result = 32'd0;
        endcase
    end

    // Evaluate the branch condition; no branch code means not taken
    always_comb begin
        case (br)
            BR_EQ:   taken = bus.a == bus.b;
            BR_NE:   taken = bus.a != bus.b;
            BR_LT:   taken = lt_s;
            BR_GE:   taken = !lt_s;
            BR_LTU:  taken = lt_u;
            BR_GEU:  taken = !lt_u;
            default: taken = 1'b0;
        endcase
    end

    // Register all outputs; reset forces the NOP control word and zero results
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.alu_ctl       <= {BR_NONE, OP_NOP};
            bus.alu_out       <= 32'd0;
            bus.branch_enable <= 1'b0;
        end else begin
            bus.alu_ctl       <= {br, op};
            bus.alu_out       <= result;
            bus.branch_enable <= taken;
        end
    end
endmodule

// File: tb/tb_alu_control.sv
// tb_alu_control: scoreboard bench for alu_control with directed cases and a mnemonic-level reference model
module tb_alu_control;
    logic clk = 1'b0;
    logic reset = 1'b1;
    alu_control_if bus ();

    alu_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  ctl;
        logic [31:0] out;
        logic        br;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;

    string imm_names [8] = '{"ADD", "SLL", "SLT", "SLTU", "XOR", "SRL", "OR", "AND"};
    string br_names  [8] = '{"BEQ", "BNE", "", "", "BLT", "BGE", "BLTU", "BGEU"};
    logic [6:0] legal_opc [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h17, 7'h6f, 7'h67, 7'h37, 7'h63};

    // Instruction mnemonic for the ALU operation
    function automatic string op_name(input logic [6:0] opc, input logic [3:0] fc);
        case (opc)
            7'h33: begin
                if (fc == 4'b1000) return "SUB";
                if (fc == 4'b1101) return "SRA";
                if (!fc[3]) return imm_names[fc[2:0]];
                return "NOP";
            end
            7'h13: return (fc[2:0] == 3'd5 && fc[3]) ? "SRA" : imm_names[fc[2:0]];
            7'h03, 7'h23, 7'h17, 7'h6f, 7'h67: return "ADD";
            7'h37: return "PASS";
            7'h63: return "SUB";
            default: return "NOP";
        endcase
    endfunction

    function automatic logic [3:0] op_code(input string m);
        case (m)
            "AND": return 4'd0;
            "OR": return 4'd1;
            "ADD": return 4'd2;
            "SRL": return 4'd3;
            "SRA": return 4'd4;
            "SLL": return 4'd5;
            "SUB": return 4'd6;
            "SLT": return 4'd7;
            "XOR": return 4'd8;
            "SLTU": return 4'd9;
            "PASS": return 4'd10;
            default: return 4'd15;
        endcase
    endfunction

    function automatic logic [2:0] br_code(input string m);
        case (m)
            "BEQ": return 3'd1;
            "BNE": return 3'd2;
            "BLT": return 3'd3;
            "BGE": return 3'd4;
            "BLTU": return 3'd5;
            "BGEU": return 3'd6;
            default: return 3'd0;
        endcase
    endfunction

    function automatic exp_t model(input logic rst, input logic [6:0] opc, input logic [3:0] fc,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        string m = op_name(opc, fc);
        string bn = (opc == 7'h63) ? br_names[fc[2:0]] : "";
        longint sa = longint'($signed(a));
        longint sb_ = longint'($signed(b));
        int sh = int'(b % 32);
        e.tag = {"rnd_", m, (bn == "") ? "" : {"_", bn}};
        if (rst) begin
            e.ctl = 7'b0001111;
            e.out = 0;
            e.br = 0;
            return e;
        end
        e.ctl = {br_code(bn), op_code(m)};
        case (m)
            "AND": e.out = a & b;
            "OR": e.out = a | b;
            "XOR": e.out = a ^ b;
            "ADD": e.out = 32'((longint'(a) + longint'(b)) % 64'h1_0000_0000);
            "SUB": e.out = 32'((longint'(a) + 64'h1_0000_0000 - longint'(b)) % 64'h1_0000_0000);
            "SLL": e.out = 32'(longint'(a) * (64'd1 << sh));
            "SRL": e.out = 32'(longint'(a) / (64'd1 << sh));
            "SRA": e.out = 32'((sa - ((sa % (64'sd1 <<< sh) + (64'sd1 <<< sh)) % (64'sd1 <<< sh))) / (64'sd1 <<< sh));
            "SLT": e.out = (sa < sb_) ? 32'd1 : 32'd0;
            "SLTU": e.out = (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
            "PASS": e.out = b;
            default: e.out = 0;
        endcase
        case (bn)
            "BEQ": e.br = a == b;
            "BNE": e.br = a != b;
            "BLT": e.br = sa < sb_;
            "BGE": e.br = sa >= sb_;
            "BLTU": e.br = longint'(a) < longint'(b);
            "BGEU": e.br = longint'(a) >= longint'(b);
            default: e.br = 0;
        endcase
        return e;
    endfunction

    task automatic drive(input logic rst, input logic [6:0] opc, input logic [3:0] fc,
                         input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        reset = rst;
        bus.opcode = opc;
        bus.func_code = fc;
        bus.a = a;
        bus.b = b;
    endtask

    task automatic check(input string tag, input logic rst, input logic [6:0] opc, input logic [3:0] fc,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [6:0] ctl, input logic [31:0] out, input logic br);
        exp_t e;
        drive(rst, opc, fc, a, b);
        e.ctl = ctl;
        e.out = out;
        e.br = br;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic rnd_issue(input logic rst, input logic [6:0] opc, input logic [3:0] fc,
                             input logic [31:0] a, input logic [31:0] b);
        drive(rst, opc, fc, a, b);
        sb.push_back(model(rst, opc, fc, a, b));
    endtask

    // Monitor: every edge, compare DUT outputs against the oldest outstanding expectation
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if (bus.alu_ctl !== e.ctl || bus.alu_out !== e.out || bus.branch_enable !== e.br) begin
                n_bad++;
                $display("FAIL %s: got ctl=%b out=%h br=%b, expected ctl=%b out=%h br=%b",
                         e.tag, bus.alu_ctl, bus.alu_out, bus.branch_enable, e.ctl, e.out, e.br);
            end
        end
    end

    initial begin
        logic [6:0] opc;
        logic [31:0] a, b;
        int wait_cycles;
        bus.opcode = 0;
        bus.func_code = 0;
        bus.a = 0;
        bus.b = 0;
        check("reset_state", 1, 7'h33, 4'b0000, 1, 2, 7'b0001111, 0, 0);
        check("and", 0, 7'h33, 4'b0111, 32'h0F, 32'h55, 7'b0000000, 32'h05, 0);
        check("or", 0, 7'h33, 4'b0110, 32'h0F, 32'h55, 7'b0000001, 32'h5F, 0);
        check("add", 0, 7'h33, 4'b0000, 10000, 111, 7'b0000010, 10111, 0);
        check("sub", 0, 7'h33, 4'b1000, 10000, 111, 7'b0000110, 9889, 0);
        check("sub_wrap", 0, 7'h33, 4'b1000, 0, 1, 7'b0000110, 32'hFFFFFFFF, 0);
        check("slt", 0, 7'h33, 4'b0010, 0, 2, 7'b0000111, 1, 0);
        check("srl", 0, 7'h33, 4'b0101, 16, 2, 7'b0000011, 4, 0);
        check("sra_pos", 0, 7'h33, 4'b1101, 8, 1, 7'b0000100, 4, 0);
        check("sra_neg", 0, 7'h33, 4'b1101, 32'h80000000, 4, 7'b0000100, 32'hF8000000, 0);
        check("sll", 0, 7'h33, 4'b0001, 2, 2, 7'b0000101, 8, 0);
        check("xor", 0, 7'h33, 4'b0100, 32'h55, 32'hFF, 7'b0001000, 32'hAA, 0);
        check("slt_signed", 0, 7'h33, 4'b0010, 32'hFFFFFFFF, 1, 7'b0000111, 1, 0);
        check("sltu", 0, 7'h33, 4'b0011, 32'hFFFFFFFF, 1, 7'b0001001, 0, 0);
        check("blt", 0, 7'h63, 4'b0100, 32'hFFFFFFFF, 1, 7'b0110110, 32'hFFFFFFFE, 1);
        check("bltu", 0, 7'h63, 4'b0110, 32'hFFFFFFFF, 1, 7'b1010110, 32'hFFFFFFFE, 0);
        check("bgeu", 0, 7'h63, 4'b0111, 32'hFFFFFFFF, 1, 7'b1100110, 32'hFFFFFFFE, 1);
        check("beq", 0, 7'h63, 4'b0000, 5, 5, 7'b0010110, 0, 1);
        check("bne", 0, 7'h63, 4'b0001, 5, 5, 7'b0100110, 0, 0);
        check("br_none", 0, 7'h63, 4'b0010, 5, 5, 7'b0000110, 0, 0);
        check("add_nobr", 0, 7'h33, 4'b0000, 5, 5, 7'b0000010, 10, 0);
        check("addi_bit3", 0, 7'h13, 4'b1000, 3, 4, 7'b0000010, 7, 0);
        check("srai_shamt", 0, 7'h13, 4'b1101, 32'h80000000, 32'hFFFFFFE4, 7'b0000100, 32'hF8000000, 0);
        check("op_bad_fc", 0, 7'h33, 4'b1111, 3, 4, 7'b0001111, 0, 0);
        check("jalr_add", 0, 7'h67, 4'b1010, 32'h1000, 32'h24, 7'b0000010, 32'h1024, 0);
        check("reset_mid_add", 1, 7'h33, 4'b0000, 10000, 111, 7'b0001111, 0, 0);
        check("lui", 0, 7'h37, 4'b0000, 32'hDEAD, 32'h12345000, 7'b0001010, 32'h12345000, 0);
        check("unknown_opc", 0, 7'h00, 4'b0000, 7, 9, 7'b0001111, 0, 0);
        for (int i = 0; i < 600; i++) begin
            opc = ($urandom_range(0, 7) == 0) ? 7'($urandom) : legal_opc[$urandom_range(0, 8)];
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = a;
                1: begin a = $urandom_range(0, 20); b = $urandom_range(0, 20); end
                2: b = {$urandom_range(0, 1) == 1 ? 27'h7FFFFFF : 27'h0, 5'($urandom)};
                default: b = $urandom;
            endcase
            rnd_issue($urandom_range(0, 29) == 0, opc, 4'($urandom), a, b);
        end
        wait_cycles = 0;
        while (sb.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        if (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations outstanding, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
